// File: rtl/ad_jesd_rx_deframer.sv
// ad_jesd_rx_deframer: 4-lane JESD frame aligner/deframer to 2 channels x 4 x 16-bit samples.
// Define AD_JESD_RX_ERR_CNT_EN to enable the saturating alignment-error counter.
module ad_jesd_rx_deframer (
    input  logic         rx_clk,
    input  logic         rx_rst,
    input  logic         rx_valid,
    input  logic [127:0] rx_data,
    input  logic [3:0]   rx_sof,
    input  logic         adc_enable_0,
    input  logic         adc_enable_1,
    output logic         adc_valid,
    output logic [63:0]  adc_data_0,
    output logic [63:0]  adc_data_1,
    output logic         status_locked,
    output logic         status_align_err,
    output logic [15:0]  status_err_count
);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] LOCKED = 2'd1;
    localparam logic [1:0] ERROR  = 2'd2;

    logic [1:0]   state;
    logic [127:0] prev;
    logic [1:0]   off;
    logic         sof_ok, match, capture, fire, mis;
    logic [1:0]   sof_idx;
    logic [31:0]  frame [4];
    logic [63:0]  ch0, ch1;

    assign sof_ok  = (rx_sof != 4'd0) && ((rx_sof & (rx_sof - 4'd1)) == 4'd0);
    assign sof_idx = {rx_sof[3] | rx_sof[2], rx_sof[3] | rx_sof[1]};
    assign match   = rx_sof == (4'd1 << off);
    assign capture = state == SEARCH && rx_valid && sof_ok;
    assign fire    = state == LOCKED && rx_valid && match;
    assign mis     = state == LOCKED && rx_valid && !match;

    // Frame = octets n..n+3 of {curr, prev}; first octet becomes the sample MSB.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [63:0] w;
        assign w = {rx_data[32*l +: 32], prev[32*l +: 32]} >> {off, 3'b000};
        assign frame[l] = {w[23:16], w[31:24], w[7:0], w[15:8]};
    end

    assign ch0 = {frame[1], frame[0]};
    assign ch1 = {frame[3], frame[2]};

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state      <= SEARCH;
            prev       <= '0;
            off        <= '0;
            adc_valid  <= 1'b0;
            adc_data_0 <= '0;
            adc_data_1 <= '0;
        end else begin
            state      <= state == SEARCH ? (capture ? LOCKED : SEARCH) :
                          state == LOCKED ? (mis ? ERROR : LOCKED) : SEARCH;
            off        <= capture ? sof_idx : off;
            prev       <= (capture || fire) ? rx_data : prev;
            adc_valid  <= fire;
            adc_data_0 <= !adc_enable_0 ? 64'd0 : fire ? ch0 : adc_data_0;
            adc_data_1 <= !adc_enable_1 ? 64'd0 : fire ? ch1 : adc_data_1;
        end
    end

    assign status_locked    = state == LOCKED;
    assign status_align_err = state == ERROR;

`ifdef AD_JESD_RX_ERR_CNT_EN
    always_ff @(posedge rx_clk) begin
        if (rx_rst)
            status_err_count <= '0;
        else if (mis && status_err_count != 16'hFFFF)
            status_err_count <= status_err_count + 16'd1;
    end
`else
    assign status_err_count = 16'h0000;
`endif
endmodule

// File: tb/tb_ad_jesd_rx_deframer.sv
// tb_ad_jesd_rx_deframer: table-driven directed bench for ad_jesd_rx_deframer.
module tb_ad_jesd_rx_deframer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [127:0] data = '0;
    logic [3:0]   sof = '0;
    logic         en0 = 1'b1;
    logic         en1 = 1'b1;
    logic         adc_valid, locked, align_err;
    logic [63:0]  d0, d1;
    logic [15:0]  err_cnt;
    int           n_chk = 0;
    int           n_fail = 0;

    typedef struct {
        logic         rst;
        logic         v;
        logic [3:0]   sof;
        logic [127:0] data;
        logic         en0;
        logic         en1;
        logic         ev;
        logic [63:0]  ed0;
        logic [63:0]  ed1;
        logic         el;
        logic         ee;
    } vec_t;

    vec_t vecs[$];

    ad_jesd_rx_deframer dut (
        .rx_clk(clk), .rx_rst(rst), .rx_valid(valid), .rx_data(data), .rx_sof(sof),
        .adc_enable_0(en0), .adc_enable_1(en1), .adc_valid(adc_valid),
        .adc_data_0(d0), .adc_data_1(d1), .status_locked(locked),
        .status_align_err(align_err), .status_err_count(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ln(input logic [31:0] l3, l2, l1, l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic add(input logic r, v, input logic [3:0] s, input logic [127:0] dt,
                       input logic e0, e1, ev, input logic [63:0] ed0, ed1, input logic el, ee);
        vec_t t;
        t.rst = r; t.v = v; t.sof = s; t.data = dt; t.en0 = e0; t.en1 = e1;
        t.ev = ev; t.ed0 = ed0; t.ed1 = ed1; t.el = el; t.ee = ee;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, v, input logic [3:0] s, input logic [127:0] dt, input logic e0, e1);
        @(negedge clk);
        rst = r; valid = v; sof = s; data = dt; en0 = e0; en1 = e1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [63:0] ed0, ed1, input logic el, ee);
        chk({tag, " adc_valid"}, {63'd0, adc_valid}, {63'd0, ev});
        chk({tag, " adc_data_0"}, d0, ed0);
        chk({tag, " adc_data_1"}, d1, ed1);
        chk({tag, " locked"}, {63'd0, locked}, {63'd0, el});
        chk({tag, " align_err"}, {63'd0, align_err}, {63'd0, ee});
    endtask

    initial begin
        logic [15:0] exp_cnt;
        add(1, 0, 4'b0000, '0, 1, 1, 0, 64'h0, 64'h0, 0, 0);
        add(0, 1, 4'b0001, ln(32'h504F4E4D, 32'h4C4B4A49, 32'h48474645, 32'h44332211), 1, 1, 0, 64'h0, 64'h0, 1, 0);
        add(0, 1, 4'b0001, ln(0, 0, 0, 32'h88776655), 1, 1, 1, 64'h47484546_33441122, 64'h4F504D4E_4B4C494A, 1, 0);
        add(0, 0, 4'b0001, '0, 1, 1, 0, 64'h47484546_33441122, 64'h4F504D4E_4B4C494A, 1, 0);
        add(0, 0, 4'b0100, '0, 1, 1, 0, 64'h47484546_33441122, 64'h4F504D4E_4B4C494A, 1, 0);
        add(0, 1, 4'b0001, '0, 1, 1, 1, 64'h0000_0000_77885566, 64'h0, 1, 0);
        add(0, 1, 4'b0010, ln(1, 2, 3, 4), 1, 1, 0, 64'h0000_0000_77885566, 64'h0, 0, 1);
        add(0, 1, 4'b0100, ln(5, 6, 7, 8), 1, 1, 0, 64'h0000_0000_77885566, 64'h0, 0, 0);
        add(0, 1, 4'b0100, ln(0, 32'hDDCCBBAA, 0, 32'hDDCCBBAA), 1, 1, 0, 64'h0000_0000_77885566, 64'h0, 1, 0);
        add(0, 1, 4'b0100, ln(0, 32'h44332211, 0, 32'h44332211), 1, 1, 1, 64'h0000_0000_1122CCDD, 64'h0000_0000_1122CCDD, 1, 0);
        add(0, 1, 4'b0100, '0, 1, 0, 1, 64'h0000_0000_0000_3344, 64'h0, 1, 0);
        add(0, 0, 4'b0100, '0, 1, 0, 0, 64'h0000_0000_0000_3344, 64'h0, 1, 0);
        add(1, 1, 4'b0100, '0, 1, 1, 0, 64'h0, 64'h0, 0, 0);
        add(0, 1, 4'b0011, ln(9, 9, 9, 9), 1, 1, 0, 64'h0, 64'h0, 0, 0);
        add(0, 1, 4'b0000, ln(9, 9, 9, 9), 1, 1, 0, 64'h0, 64'h0, 0, 0);
        add(0, 1, 4'b1000, ln(0, 0, 0, 32'h11223344), 1, 1, 0, 64'h0, 64'h0, 1, 0);
        add(1, 1, 4'b1000, ln(0, 0, 0, 32'h99999999), 1, 1, 0, 64'h0, 64'h0, 0, 0);
        add(0, 1, 4'b1000, ln(0, 0, 0, 32'hAABBCCDD), 1, 1, 0, 64'h0, 64'h0, 1, 0);
        add(0, 1, 4'b1000, ln(0, 0, 0, 32'h55667788), 1, 1, 1, 64'h0000_0000_7766AA88, 64'h0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].sof, vecs[i].data, vecs[i].en0, vecs[i].en1);
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed0, vecs[i].ed1, vecs[i].el, vecs[i].ee);
            if (vecs[i].rst) chk($sformatf("vec%0d err_count", i), {48'd0, err_cnt}, 64'd0);
        end

        // Five-cycle gap: prev word (0x55667788, offset 3) must survive.
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 4'b0000, ln(7, 7, 7, 7), 1, 1);
            chk_out($sformatf("gap%0d", i), 0, 64'h0000_0000_7766AA88, 64'h0, 1, 0);
        end
        step(0, 1, 4'b1000, '0, 1, 1);
        chk_out("gap_end", 1, 64'h0000_0000_0000_5500, 64'h0, 1, 0);

        // Three misalign events with relock in between.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'b0001, '0, 1, 1);
            chk($sformatf("mis%0d align_err", i), {63'd0, align_err}, 64'd1);
            chk($sformatf("mis%0d adc_valid", i), {63'd0, adc_valid}, 64'd0);
            step(0, 0, 4'b0000, '0, 1, 1);
            chk($sformatf("mis%0d err_drop", i), {63'd0, align_err}, 64'd0);
            step(0, 1, 4'b1000, '0, 1, 1);
            chk($sformatf("mis%0d relock", i), {63'd0, locked}, 64'd1);
        end
`ifdef AD_JESD_RX_ERR_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        chk("err_count", {48'd0, err_cnt}, {48'd0, exp_cnt});

        step(1, 1, 4'b1000, '0, 1, 1);
        chk_out("final_rst", 0, 64'h0, 64'h0, 0, 0);
        chk("final_rst err_count", {48'd0, err_cnt}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ad_jesd_rx_deframer.md
AD_JESD_RX_DEFRAMER -- requirements
Module: ad_jesd_rx_deframer

Interface
REQ-001 SHALL have no parameters; fixed 4 lanes x 32 bits, frame = 4 octets per lane, 2 channels x 4 samples x 16 bits.
REQ-002 rx_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 rx_rst  input  1  reset, synchronous to rx_clk, active-high.
REQ-004 rx_valid  input  1  rx_data/rx_sof beat valid.
REQ-005 rx_data  input  128  lane l at [32l+31:32l]; octet k of lane at [32l+8k+7:32l+8k], octet 0 received first.
REQ-006 rx_sof  input  4  start-of-frame octet position, one-hot, common to all lanes.
REQ-007 adc_enable_0, adc_enable_1  input  1 each  channel enables.
REQ-008 adc_valid  output  1  adc_data_0/adc_data_1 valid this cycle.
REQ-009 adc_data_0, adc_data_1  output  64 each  4 samples, sample 0 in [15:0].
REQ-010 status_locked  output  1  frame alignment held.
REQ-011 status_align_err  output  1  one-cycle pulse on alignment loss.
REQ-012 status_err_count  output  16  alignment-error count (see Configuration).

Function
REQ-013 FSM states SEARCH, LOCKED, ERROR; SEARCH -> LOCKED on rx_valid with one-hot rx_sof, capturing offset n (index of set bit) and current beat as prev word.
REQ-014 LOCKED -> ERROR on rx_valid with rx_sof != captured one-hot; ERROR -> SEARCH unconditionally next cycle; ERROR beat discarded.
REQ-015 In LOCKED, each rx_valid beat after the capture beat completes one frame per lane: octets prev[n..3] followed by curr[0..n-1] (n=0: prev word entire); curr then becomes prev.
REQ-016 Frame octets f0..f3 map to sample0={f0,f1}, sample1={f2,f3} (f0 = MSB).
REQ-017 Channel 0 samples 0..3 = lane0 s0, lane0 s1, lane1 s0, lane1 s1; channel 1 likewise from lanes 2,3.
REQ-018 Latency: adc_valid and data asserted exactly one rx_clk after the completing rx_valid beat; registered outputs.
REQ-019 rx_valid low: no state change, prev word held, adc_valid low next cycle; gaps of any length tolerated.
REQ-020 adc_data_x = 0 while adc_enable_x low; adc_valid independent of enables.
REQ-021 adc_data_0/1 hold last value when adc_valid low.
REQ-022 status_locked = 1 iff state LOCKED; status_align_err high for exactly the cycle state is ERROR.
REQ-023 rx_sof ignored when rx_valid low; rx_sof zero or multi-hot with rx_valid in SEARCH keeps SEARCH.

Reset
REQ-024 rx_rst high: state SEARCH, prev word 0, offset 0, adc_valid 0, adc_data_0/1 0, status_locked 0, status_align_err 0, status_err_count 0.
REQ-025 rx_rst mid-frame drops in-flight frame; no adc_valid in the cycle after rx_rst deasserts.

Configuration
REQ-026 Macro AD_JESD_RX_ERR_CNT_EN defined: status_err_count increments on each entry to ERROR, saturates at 16'hFFFF, cleared only by rx_rst.
REQ-027 Macro undefined: counter logic absent; status_err_count tied to 16'h0000; all other behaviour identical.

Verification
REQ-028 Aligned: rx_sof=4'b0001 every beat, lane0 words 0x44332211 then 0x88776655 -> after 2nd beat +1 cycle, adc_valid=1, adc_data_0[31:0]=0x33441122.
REQ-029 Offset 2: rx_sof=4'b0100, lane0 beats 0xDDCCBBAA, 0x44332211 -> frame octets CC,DD,11,22; adc_data_0[31:0]=0x1122CCDD.
REQ-030 Gap: rx_valid low 5 cycles between locked beats -> no adc_valid during gap; next beat yields correct frame from held prev word.
REQ-031 Misalign: locked on 4'b0001, then rx_sof=4'b0010 -> status_align_err pulse 1 cycle, status_locked 0, no adc_valid for that beat; relock on next one-hot beat.
REQ-032 adc_enable_1=0 -> adc_data_1=0 with adc_valid toggling; with AD_JESD_RX_ERR_CNT_EN, 3 misalign events -> status_err_count=3; without, stays 0.
REQ-033 rx_rst asserted in LOCKED mid-stream -> all outputs 0 next cycle; state SEARCH.
